// File: rtl/updown_counter_sequencer.sv
// Command sequencer for the up/down counter: LOAD, STEP_UP/STEP_DOWN by N, RUN_TO target.
// Define SEQ_TIMEOUT_EN to abort RUN_TO with err after TIMEOUT unmatched steps.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high while ena
// LOAD  | cnt_load asserted with the latched value
// STEP  | cnt_en asserted, step counter counting down remaining steps
// CHK   | RUN_TO: compare counter against target
// RSTEP | RUN_TO: single cnt_en pulse toward target
// DONE  | done pulse (with err on RUN_TO timeout), back to IDLE
module updown_counter_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_en,
  output logic             cnt_dir,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             busy,
  output logic             done,
  output logic             err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_STEP  = 3'd2,
    S_CHK   = 3'd3,
    S_RSTEP = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_RUN  = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] arg_q, arg_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [WIDTH-1:0] load_val_q, load_val_d;
  logic             en_q, en_d;
  logic             dir_q, dir_d;
  logic             load_q, load_d;
  logic             done_q, done_d;
  logic             accept;

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  assign cmd_ready = (state_q == S_IDLE) & ena;
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    state_d    = state_q;
    arg_d      = arg_q;
    step_d     = step_q;
    load_val_d = load_val_q;
    en_d       = 1'b0;
    dir_d      = dir_q;
    load_d     = 1'b0;
    done_d     = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    tmo_d      = tmo_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          arg_d = cmd_arg;
          case (cmd_op)
            OP_LOAD: begin
              state_d    = S_LOAD;
              load_d     = 1'b1;
              load_val_d = cmd_arg;
            end
            OP_UP, OP_DOWN: begin
              dir_d = (cmd_op == OP_UP);
              if (cmd_arg == '0) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = S_STEP;
                en_d    = 1'b1;
                step_d  = cmd_arg - WIDTH'(1);
              end
            end
            default: begin
              state_d = S_CHK;
`ifdef SEQ_TIMEOUT_EN
              tmo_d   = TW'(TIMEOUT);
`endif
            end
          endcase
        end
      end
      S_LOAD: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_STEP: begin
        if (step_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          en_d   = 1'b1;
          step_d = step_q - WIDTH'(1);
        end
      end
      S_CHK: begin
        if (cnt_value == arg_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
`ifdef SEQ_TIMEOUT_EN
          if (tmo_q == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = S_RSTEP;
            en_d    = 1'b1;
            dir_d   = (arg_q > cnt_value);
            tmo_d   = tmo_q - TW'(1);
          end
`else
          state_d = S_RSTEP;
          en_d    = 1'b1;
          dir_d   = (arg_q > cnt_value);
`endif
        end
      end
      // the counter updates one cycle after cnt_en, so CHK sees the new value
      S_RSTEP: state_d = S_CHK;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      arg_q      <= '0;
      step_q     <= '0;
      load_val_q <= '0;
      en_q       <= 1'b0;
      dir_q      <= 1'b0;
      load_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (ena) begin
      state_q    <= state_d;
      arg_q      <= arg_d;
      step_q     <= step_d;
      load_val_q <= load_val_d;
      en_q       <= en_d;
      dir_q      <= dir_d;
      load_q     <= load_d;
      done_q     <= done_d;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else if (ena) begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err = err_q & ena;
`else
  assign err = 1'b0;
`endif

  // ena low masks the strobes for that cycle; the registers hold and resume later
  assign cnt_en       = en_q & ena;
  assign cnt_load     = load_q & ena;
  assign done         = done_q & ena;
  assign cnt_dir      = dir_q;
  assign cnt_load_val = load_val_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_updown_counter_sequencer.sv
// Scoreboard bench for updown_counter_sequencer with a behavioural counter model.
// Expected strobe/done events are queued per command and matched against observed events.
module tb_updown_counter_sequencer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_arg = '0;
  logic [W-1:0] cnt_value;
  logic         cnt_en, cnt_dir, cnt_load;
  logic [W-1:0] cnt_load_val;
  logic         busy, done, err;

  updown_counter_sequencer #(.WIDTH(W), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cnt_value(cnt_value), .cnt_en(cnt_en), .cnt_dir(cnt_dir), .cnt_load(cnt_load),
    .cnt_load_val(cnt_load_val), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // counter datapath model; stuck freezes stepping to force a RUN_TO timeout
  logic [W-1:0] cnt_q;
  logic         stuck = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt_q <= '0;
    else if (cnt_load)           cnt_q <= cnt_load_val;
    else if (cnt_en && !stuck)   cnt_q <= cnt_dir ? cnt_q + 8'd1 : cnt_q - 8'd1;
  end
  assign cnt_value = cnt_q;

  localparam int EV_EN = 0, EV_LOAD = 1, EV_DONE = 2;
  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;
  ev_t exp_q[$];
  ev_t obs_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic ev_t mk(input int kind, input int c, input int v);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (cnt_en && cnt_load) check("en_load_excl", 32'd1, 32'd0);
      if (cnt_en)   obs_q.push_back(mk(EV_EN, cyc, int'(cnt_dir)));
      if (cnt_load) obs_q.push_back(mk(EV_LOAD, cyc, int'(cnt_load_val)));
      if (done)     obs_q.push_back(mk(EV_DONE, cyc, int'(err)));
    end
  end

  task automatic push_exp(input int kind, input int c, input int v);
    exp_q.push_back(mk(kind, c, v));
  endtask

  task automatic score(input string name);
    ev_t e, o;
    check({name, "_events"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({name, "_kind"}, o.kind, e.kind);
      check({name, "_cyc"},  o.cyc,  e.cyc);
      check({name, "_val"},  o.val,  e.val);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // called at posedge+1; returns t1 = first cycle after the accept edge
  task automatic send(input logic [1:0] op, input logic [W-1:0] arg, output int t1);
    check("ready_before_cmd", cmd_ready, 1);
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    t1 = cyc;
  endtask

  task automatic wait_idle(input int done_cyc);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_cycle", cyc, done_cyc + 1);
    check("ready_after_done", cmd_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    int t1;
    send(2'b00, v, t1);
    push_exp(EV_LOAD, t1, int'(v));
    push_exp(EV_DONE, t1 + 1, 0);
    wait_idle(t1 + 1);
    score("load");
  endtask

  task automatic do_step(input logic up, input int n);
    int t1;
    send(up ? 2'b01 : 2'b10, W'(n), t1);
    for (int i = 0; i < n; i++) push_exp(EV_EN, t1 + i, int'(up));
    push_exp(EV_DONE, t1 + n, 0);
    wait_idle(t1 + n);
    score(up ? "step_up" : "step_down");
  endtask

  task automatic do_run_to(input int target, input int start);
    int t1, k, dir;
    k   = (target > start) ? target - start : start - target;
    dir = (target > start) ? 1 : 0;
    send(2'b11, W'(target), t1);
    for (int i = 0; i < k; i++) push_exp(EV_EN, t1 + 1 + 2 * i, dir);
    push_exp(EV_DONE, t1 + 2 * k + 1, 0);
    wait_idle(t1 + 2 * k + 1);
    score("run_to");
    check("run_to_cnt", cnt_value, W'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cnt_en", cnt_en, 0);
    check("rst_cnt_load", cnt_load, 0);
    check("rst_load_val", cnt_load_val, 0);
    check("rst_dir", cnt_dir, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    @(posedge clk); #1;

    // reset in the middle of STEP_UP 10 aborts without done
    send(2'b01, 8'd10, t1);
    for (int i = 0; i < 3; i++) push_exp(EV_EN, t1 + i, 1);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst_cnt_en", cnt_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_dir", cnt_dir, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", cmd_ready, 1);
    repeat (15) @(negedge clk);
    score("midrst");
    @(posedge clk); #1;

    do_load(8'h5A);
    check("load_cnt", cnt_value, 8'h5A);

    do_load(8'h01);
    do_step(1'b0, 3);
    check("step_down_wrap", cnt_value, 8'hFE);
    do_step(1'b1, 0);
    check("step_zero_cnt", cnt_value, 8'hFE);

    do_load(8'h02);
    do_run_to(5, 2);
    do_run_to(2, 5);
    do_run_to(2, 2);

    // ena low for 4 cycles in STEP_UP 5; a command offered while busy is dropped
    send(2'b01, 8'd5, t1);
    push_exp(EV_EN, t1, 1);
    push_exp(EV_EN, t1 + 1, 1);
    push_exp(EV_EN, t1 + 6, 1);
    push_exp(EV_EN, t1 + 7, 1);
    push_exp(EV_EN, t1 + 8, 1);
    push_exp(EV_DONE, t1 + 9, 0);
    @(posedge clk); #1;
    cmd_op    = 2'b00;
    cmd_arg   = 8'h33;
    cmd_valid = 1'b1;
    check("busy_not_ready", cmd_ready, 0);
    @(posedge clk); #1;
    ena = 1'b0;
    check("ena_low_ready", cmd_ready, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) cmd_valid = 1'b0;
      @(posedge clk); #1;
    end
    ena = 1'b1;
    wait_idle(t1 + 9);
    score("ena_stall");
    check("ena_stall_cnt", cnt_value, 8'h07);

    // RUN_TO against a frozen counter
    do_load(8'h00);
    stuck = 1'b1;
    send(2'b11, 8'h10, t1);
`ifdef SEQ_TIMEOUT_EN
    for (int i = 0; i < 4; i++) push_exp(EV_EN, t1 + 1 + 2 * i, 1);
    push_exp(EV_DONE, t1 + 9, 1);
    wait_idle(t1 + 9);
    score("timeout");
`else
    for (int i = 0; i < 10; i++) push_exp(EV_EN, t1 + 1 + 2 * i, 1);
    repeat (20) begin @(posedge clk); #1; end
    check("no_timeout_busy", busy, 1);
    check("no_timeout_err", err, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    score("no_timeout");
    @(posedge clk); #1;
`endif
    stuck = 1'b0;
    check("stuck_cnt", cnt_value, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
